// File: rtl/id_ex_hazard_reg.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_reg
//
// ID/EX pipeline register with load-use hazard detection and a hold for
// multi-cycle FP operations occupying the EX stage.
//
// Ports
//   CLK, rst_n          clock (rising edge), asynchronous active-low reset
//   id_valid            decode slot holds a real instruction
//   id_rs1/rs2/rd       decoded register indices
//   id_reg_wr           instruction writes a register
//   id_mem_rd           instruction is a load
//   id_int_op/fp_op     operand class of the decoded instruction
//   id_i2f_op           int-to-FP move/convert (sources come from the int file)
//   id_multi            multi-cycle FP operation
//   flush               taken branch/jump in EX; kill the instruction in ID
//   ID_EX_*             registered instruction fields seen by EX / forwarding
//   *_op_id_ex          registered operand class bits
//   ex_busy             a multi-cycle op still occupies EX
//   stall               hold PC and IF/ID this cycle (combinational)
// -----------------------------------------------------------------------------
module id_ex_hazard_reg #(
    parameter int unsigned WIDTH_SOURCE = 5,
    parameter int unsigned FP_LAT       = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [WIDTH_SOURCE-1:0] id_rs1,
    input  logic [WIDTH_SOURCE-1:0] id_rs2,
    input  logic [WIDTH_SOURCE-1:0] id_rd,
    input  logic                    id_reg_wr,
    input  logic                    id_mem_rd,
    input  logic                    id_int_op,
    input  logic                    id_fp_op,
    input  logic                    id_i2f_op,
    input  logic                    id_multi,
    input  logic                    flush,
    output logic                    ID_EX_valid,
    output logic [WIDTH_SOURCE-1:0] ID_EX_rs1,
    output logic [WIDTH_SOURCE-1:0] ID_EX_rs2,
    output logic [WIDTH_SOURCE-1:0] ID_EX_rd,
    output logic                    ID_EX_Reg_Wr,
    output logic                    ID_EX_Mem_Rd,
    output logic                    int_op_id_ex,
    output logic                    fp_op_id_ex,
    output logic                    i2f_op_id_ex,
    output logic                    ex_busy,
    output logic                    stall
);

    // Busy cycles remaining after the load cycle of a multi-cycle op.
    localparam logic [CNT_W-1:0] BUSY_INIT = CNT_W'(FP_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Pipeline register state
    // -------------------------------------------------------------------------
    logic                    valid_q,  valid_d;
    logic [WIDTH_SOURCE-1:0] rs1_q,    rs1_d;
    logic [WIDTH_SOURCE-1:0] rs2_q,    rs2_d;
    logic [WIDTH_SOURCE-1:0] rd_q,     rd_d;
    logic                    reg_wr_q, reg_wr_d;
    logic                    mem_rd_q, mem_rd_d;
    logic                    int_op_q, int_op_d;
    logic                    fp_op_q,  fp_op_d;
    logic                    i2f_op_q, i2f_op_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;

    logic class_match;
    logic src_match;
    logic load_use;
    logic busy;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    always_comb begin
        // An integer producer feeds both integer consumers and i2f moves,
        // which read their source from the integer file. FP producers only
        // feed FP consumers; any other pairing uses separate register files.
        class_match = (int_op_q & (id_int_op | id_i2f_op)) |
                      (fp_op_q  & id_fp_op);

        src_match   = (rd_q == id_rs1) | (rd_q == id_rs2);

        // x0 is never a real dependency; non-load producers are covered by
        // EX forwarding, so only a load in EX can force a bubble.
        load_use    = valid_q & mem_rd_q & reg_wr_q & (rd_q != '0) &
                      id_valid & class_match & src_match;

        busy        = (cnt_q != '0);
        stall       = ~flush & (busy | load_use);
    end

    // -------------------------------------------------------------------------
    // Next-state selection: flush > busy hold > load-use bubble > load
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d  = valid_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        reg_wr_d = reg_wr_q;
        mem_rd_d = mem_rd_q;
        int_op_d = int_op_q;
        fp_op_d  = fp_op_q;
        i2f_op_d = i2f_op_q;
        cnt_d    = cnt_q;

        if (flush) begin
            // Flush also abandons any multi-cycle op still in EX.
            valid_d  = 1'b0;
            rs1_d    = '0;
            rs2_d    = '0;
            rd_d     = '0;
            reg_wr_d = 1'b0;
            mem_rd_d = 1'b0;
            int_op_d = 1'b0;
            fp_op_d  = 1'b0;
            i2f_op_d = 1'b0;
            cnt_d    = '0;
        end else if (busy) begin
            // Hold every field; only the occupancy counter moves.
            cnt_d    = cnt_q - CNT_ONE;
        end else if (load_use) begin
            // One bubble; the counter is already zero here.
            valid_d  = 1'b0;
            rs1_d    = '0;
            rs2_d    = '0;
            rd_d     = '0;
            reg_wr_d = 1'b0;
            mem_rd_d = 1'b0;
            int_op_d = 1'b0;
            fp_op_d  = 1'b0;
            i2f_op_d = 1'b0;
        end else begin
            valid_d  = id_valid;
            rs1_d    = id_rs1;
            rs2_d    = id_rs2;
            rd_d     = id_rd;
            reg_wr_d = id_reg_wr & id_valid;
            mem_rd_d = id_mem_rd & id_valid;
            int_op_d = id_int_op & id_valid;
            fp_op_d  = id_fp_op  & id_valid;
            i2f_op_d = id_i2f_op & id_valid;
            cnt_d    = (id_valid & id_multi) ? BUSY_INIT : '0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            reg_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            int_op_q <= 1'b0;
            fp_op_q  <= 1'b0;
            i2f_op_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            reg_wr_q <= reg_wr_d;
            mem_rd_q <= mem_rd_d;
            int_op_q <= int_op_d;
            fp_op_q  <= fp_op_d;
            i2f_op_q <= i2f_op_d;
            cnt_q    <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ID_EX_valid  = valid_q;
    assign ID_EX_rs1    = rs1_q;
    assign ID_EX_rs2    = rs2_q;
    assign ID_EX_rd     = rd_q;
    assign ID_EX_Reg_Wr = reg_wr_q;
    assign ID_EX_Mem_Rd = mem_rd_q;
    assign int_op_id_ex = int_op_q;
    assign fp_op_id_ex  = fp_op_q;
    assign i2f_op_id_ex = i2f_op_q;
    assign ex_busy      = busy;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_hazard_reg
//
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model of what instruction occupies EX and for how long.
// -----------------------------------------------------------------------------
module tb_id_ex_hazard_reg;

    localparam int W      = 5;
    localparam int FP_LAT = 4;
    localparam int CNT_W  = 3;

    logic         CLK = 1'b0;
    logic         rst_n;
    logic         id_valid, id_reg_wr, id_mem_rd, id_int_op, id_fp_op, id_i2f_op;
    logic         id_multi, flush;
    logic [W-1:0] id_rs1, id_rs2, id_rd;
    logic         ID_EX_valid, ID_EX_Reg_Wr, ID_EX_Mem_Rd;
    logic [W-1:0] ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic         int_op_id_ex, fp_op_id_ex, i2f_op_id_ex, ex_busy, stall;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_hazard_reg #(
        .WIDTH_SOURCE (W),
        .FP_LAT       (FP_LAT),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_wr    (id_reg_wr),
        .id_mem_rd    (id_mem_rd),
        .id_int_op    (id_int_op),
        .id_fp_op     (id_fp_op),
        .id_i2f_op    (id_i2f_op),
        .id_multi     (id_multi),
        .flush        (flush),
        .ID_EX_valid  (ID_EX_valid),
        .ID_EX_rs1    (ID_EX_rs1),
        .ID_EX_rs2    (ID_EX_rs2),
        .ID_EX_rd     (ID_EX_rd),
        .ID_EX_Reg_Wr (ID_EX_Reg_Wr),
        .ID_EX_Mem_Rd (ID_EX_Mem_Rd),
        .int_op_id_ex (int_op_id_ex),
        .fp_op_id_ex  (fp_op_id_ex),
        .i2f_op_id_ex (i2f_op_id_ex),
        .ex_busy      (ex_busy),
        .stall        (stall)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model: contents of EX + remaining busy cycles
    typedef struct {
        int valid, rs1, rs2, rd, wr, mrd, io, fo, i2f;
    } ex_t;

    ex_t m_ex;
    int  m_busy_left;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int m_hazard();
        int producer_is_load, consumer_reads, same_file;
        producer_is_load = m_ex.valid && m_ex.mrd && m_ex.wr && (m_ex.rd != 0);
        consumer_reads   = (m_ex.rd == int'(id_rs1)) || (m_ex.rd == int'(id_rs2));
        same_file        = (m_ex.io && (id_int_op || id_i2f_op)) || (m_ex.fo && id_fp_op);
        return (producer_is_load && id_valid && same_file && consumer_reads) ? 1 : 0;
    endfunction

    function automatic int m_stall();
        return (!flush && (m_busy_left > 0 || m_hazard() != 0)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_ex        = '{default: 0};
        m_busy_left = 0;
    endtask

    task automatic model_edge();
        if (flush) begin
            m_ex        = '{default: 0};
            m_busy_left = 0;
        end else if (m_busy_left > 0) begin
            m_busy_left = m_busy_left - 1;
        end else if (m_hazard() != 0) begin
            m_ex = '{default: 0};
        end else begin
            m_ex.valid  = int'(id_valid);
            m_ex.rs1    = int'(id_rs1);
            m_ex.rs2    = int'(id_rs2);
            m_ex.rd     = int'(id_rd);
            m_ex.wr     = int'(id_reg_wr & id_valid);
            m_ex.mrd    = int'(id_mem_rd & id_valid);
            m_ex.io     = int'(id_int_op & id_valid);
            m_ex.fo     = int'(id_fp_op  & id_valid);
            m_ex.i2f    = int'(id_i2f_op & id_valid);
            m_busy_left = (id_valid && id_multi) ? FP_LAT - 1 : 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"},  32'(ID_EX_valid),  32'(m_ex.valid));
        chk({tag, "_rs1"},    32'(ID_EX_rs1),    32'(m_ex.rs1));
        chk({tag, "_rs2"},    32'(ID_EX_rs2),    32'(m_ex.rs2));
        chk({tag, "_rd"},     32'(ID_EX_rd),     32'(m_ex.rd));
        chk({tag, "_regwr"},  32'(ID_EX_Reg_Wr), 32'(m_ex.wr));
        chk({tag, "_memrd"},  32'(ID_EX_Mem_Rd), 32'(m_ex.mrd));
        chk({tag, "_int"},    32'(int_op_id_ex), 32'(m_ex.io));
        chk({tag, "_fp"},     32'(fp_op_id_ex),  32'(m_ex.fo));
        chk({tag, "_i2f"},    32'(i2f_op_id_ex), 32'(m_ex.i2f));
        chk({tag, "_busy"},   32'(ex_busy),      32'(m_busy_left > 0));
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic cycle(input string tag);
        #1;
        chk({tag, "_stall"},    32'(stall),   32'(m_stall()));
        chk({tag, "_busy_pre"}, 32'(ex_busy), 32'(m_busy_left > 0));
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                         input logic wr, input logic mrd, input logic io,
                         input logic fo, input logic i2f, input logic multi,
                         input logic fl);
        id_valid  = v;
        id_rs1    = W'(rs1);
        id_rs2    = W'(rs2);
        id_rd     = W'(rd);
        id_reg_wr = wr;
        id_mem_rd = mrd;
        id_int_op = io;
        id_fp_op  = fo;
        id_i2f_op = i2f;
        id_multi  = multi;
        flush     = fl;
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        @(negedge CLK);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge CLK);

        // 1: reset, then a plain integer op loads in one cycle
        do_reset("tp1_rst");
        drive(1, 3, 4, 5, 1, 0, 1, 0, 0, 0, 0);
        cycle("tp1");
        chk("tp1_rs1_k",   32'(ID_EX_rs1),    32'd3);
        chk("tp1_rd_k",    32'(ID_EX_rd),     32'd5);
        chk("tp1_regwr_k", 32'(ID_EX_Reg_Wr), 32'd1);
        chk("tp1_int_k",   32'(int_op_id_ex), 32'd1);
        chk("tp1_stall_k", 32'(stall),        32'd0);

        // 2: load-use gives exactly one bubble
        drive(1, 1, 2, 7, 1, 1, 1, 0, 0, 0, 0);
        cycle("tp2_ld");
        drive(1, 1, 7, 8, 1, 0, 1, 0, 0, 0, 0);
        #1 chk("tp2_stall_k", 32'(stall), 32'd1);
        cycle("tp2_bub");
        chk("tp2_valid_k", 32'(ID_EX_valid),  32'd0);
        chk("tp2_regwr_k", 32'(ID_EX_Reg_Wr), 32'd0);
        cycle("tp2_use");
        chk("tp2_rs2_k",    32'(ID_EX_rs2), 32'd7);
        chk("tp2_stall2_k", 32'(stall),     32'd0);

        // 3: class mismatch and x0 raise no hazard
        drive(1, 1, 2, 7, 1, 1, 1, 0, 0, 0, 0);
        cycle("tp3_ld");
        drive(1, 7, 2, 9, 1, 0, 0, 1, 0, 0, 0);
        #1 chk("tp3_cls_k", 32'(stall), 32'd0);
        cycle("tp3_fp");
        drive(1, 1, 2, 0, 1, 1, 1, 0, 0, 0, 0);
        cycle("tp3_ld0");
        drive(1, 0, 2, 6, 1, 0, 1, 0, 0, 0, 0);
        #1 chk("tp3_x0_k", 32'(stall), 32'd0);
        cycle("tp3_x0");

        // 4: multi-cycle FP op holds EX for FP_LAT cycles
        drive(1, 1, 2, 9, 1, 0, 0, 1, 0, 1, 0);
        cycle("tp4_div");
        drive(1, 3, 4, 10, 1, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < FP_LAT - 1; k++) begin
            #1 chk("tp4_stall_k", 32'(stall), 32'd1);
            cycle("tp4_hold");
            chk("tp4_rd_held_k", 32'(ID_EX_rd), 32'd9);
        end
        cycle("tp4_next");
        chk("tp4_rd_next_k", 32'(ID_EX_rd), 32'd10);
        chk("tp4_busy_k",    32'(ex_busy),  32'd0);

        // 5: flush overrides an active busy window
        drive(1, 1, 2, 11, 1, 0, 0, 1, 0, 1, 0);
        cycle("tp5_div");
        drive(1, 3, 4, 12, 1, 0, 0, 1, 0, 0, 0);
        cycle("tp5_hold");
        drive(1, 3, 4, 12, 1, 0, 0, 1, 0, 0, 1);
        #1 chk("tp5_stall_k", 32'(stall), 32'd0);
        cycle("tp5_flush");
        chk("tp5_valid_k", 32'(ID_EX_valid), 32'd0);
        chk("tp5_busy_k",  32'(ex_busy),     32'd0);

        // 6: reset during the busy window leaves no residual stall
        drive(1, 1, 2, 13, 1, 0, 0, 1, 0, 1, 0);
        cycle("tp6_div");
        chk("tp6_busy_k", 32'(ex_busy), 32'd1);
        do_reset("tp6_rst");
        drive(1, 5, 6, 14, 1, 0, 1, 0, 0, 0, 0);
        cycle("tp6_after");
        chk("tp6_rd_k", 32'(ID_EX_rd), 32'd14);

        // Randomized traffic with a small register range to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            int cls;
            if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
            cls = $urandom_range(0, 3);
            drive($urandom_range(0, 9) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 4) != 0, $urandom_range(0, 4) < 2,
                  cls == 0, cls == 1, cls == 2,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register with load-use hazard detection and multi-cycle FP hold.
- Captures decoded source/destination indices, write-enable, memory-read flag and operand-class bits from decode.
- Presents them as the ID_EX_* / *_op_id_ex signals that the forwarding unit and the EX stage consume.
- Generates the stall that freezes PC and IF/ID, and inserts bubbles when forwarding cannot resolve a dependency.

Parameters:
- WIDTH_SOURCE, 5: register index width.
- FP_LAT, 4: EX occupancy in cycles of a multi-cycle FP op; legal range 2..(2^CNT_W).
- CNT_W, 3: width of the busy counter.

Ports:
- CLK  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  decode slot holds a real instruction.
- id_rs1  input  WIDTH_SOURCE  decoded rs1.
- id_rs2  input  WIDTH_SOURCE  decoded rs2.
- id_rd  input  WIDTH_SOURCE  decoded rd.
- id_reg_wr  input  1  instruction writes a register.
- id_mem_rd  input  1  instruction is a load.
- id_int_op  input  1  integer-class instruction.
- id_fp_op  input  1  FP-class instruction.
- id_i2f_op  input  1  int-to-FP move/convert; reads the integer file.
- id_multi  input  1  multi-cycle FP op.
- flush  input  1  branch/jump taken in EX; kill the instruction in ID.
- ID_EX_valid  output  1  EX holds a real instruction.
- ID_EX_rs1  output  WIDTH_SOURCE  registered rs1.
- ID_EX_rs2  output  WIDTH_SOURCE  registered rs2.
- ID_EX_rd  output  WIDTH_SOURCE  registered rd.
- ID_EX_Reg_Wr  output  1  registered write-enable, gated by valid.
- ID_EX_Mem_Rd  output  1  registered load flag, gated by valid.
- int_op_id_ex  output  1  registered integer class.
- fp_op_id_ex  output  1  registered FP class.
- i2f_op_id_ex  output  1  registered i2f class.
- ex_busy  output  1  multi-cycle op occupying EX.
- stall  output  1  hold PC and IF/ID this cycle (combinational).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all ID_EX_* and *_op_id_ex outputs are 0; ID_EX_valid=0.
  - counter is 0; ex_busy=0; stall=0.
  - Reset mid multi-cycle op abandons it with no residual stall.
- Class match (producer in EX, consumer in ID):
  - int_op_id_ex=1 matches id_int_op or id_i2f_op.
  - fp_op_id_ex=1 matches id_fp_op.
  - Otherwise there is no dependency: separate register files.
- load_use (combinational) = ID_EX_valid & ID_EX_Mem_Rd & ID_EX_Reg_Wr & (ID_EX_rd!=0) & id_valid & class match & (ID_EX_rd==id_rs1 | ID_EX_rd==id_rs2).
- ex_busy = (counter!=0).
- stall = !flush & (ex_busy | load_use).
- Register update priority, evaluated each rising edge:
  1. flush=1: clear all ID_EX fields to 0 (bubble); counter<=0. Flush overrides busy and load_use.
  2. ex_busy=1: hold all ID_EX fields; counter<=counter-1.
  3. load_use=1: load a bubble (all fields 0); counter unchanged (0).
  4. Otherwise:
     - load all fields from id_* inputs.
     - ID_EX_Reg_Wr<=id_reg_wr&id_valid; ID_EX_Mem_Rd<=id_mem_rd&id_valid; class bits likewise gated by id_valid.
     - If id_valid&id_multi: counter<=FP_LAT-1, else counter<=0.
- Occupancy and stalls:
  - A multi-cycle op occupies EX for exactly FP_LAT cycles: 1 load cycle plus FP_LAT-1 busy cycles.
  - stall is asserted for FP_LAT-1 cycles.
- Load-use timing: exactly one bubble per load-use pair. After the bubble the load has reached MEM/WB and the forwarding unit resolves the dependency through MEM forwarding.
- No hazard is raised for ID_EX_rd==0.
- No hazard is raised for a non-load producer; EX forwarding covers it.
- Busy and load-use together: busy wins. When busy drops, load_use is re-evaluated against the held instruction.
- Latency: ID to ID_EX outputs is 1 cycle when no stall is active.

Test Plan:
1. Reset: rst_n=0 asserted mid-cycle → all outputs 0 immediately, without waiting for a CLK edge. Release, then id_valid=1, rs1=3, rs2=4, rd=5, id_reg_wr=1, int → next edge: ID_EX_rs1=3, ID_EX_rd=5, ID_EX_Reg_Wr=1, int_op_id_ex=1, stall=0.
2. Load-use: load rd=7 (int) in EX, ID is int add rs2=7 → stall=1 for 1 cycle; next edge ID_EX_valid=0, ID_EX_Reg_Wr=0; following edge ID_EX_rs2=7 loaded, stall=0.
3. Class mismatch or x0: int load rd=7, ID fp op rs1=7 → stall=0. Load rd=0, ID rs1=0 → stall=0.
4. Multi-cycle with FP_LAT=4: fdiv enters EX → ex_busy=1 and stall=1 for 3 cycles, ID_EX fields constant; on cycle 4 the next instruction loads.
5. Flush precedence: flush=1 while ex_busy=1 with 2 cycles remaining → stall=0 that cycle; next edge ID_EX_valid=0, ex_busy=0.
6. Reset mid-busy: assert rst_n=0 during the busy window → ex_busy=0 and stall=0 immediately; after release the next id input loads normally.
